// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one full-subtractor cell plus a borrow flop, LSB first.
// Optional signed-overflow output is enabled by defining SERSUB_SIGNED_OVF_EN.
module serial_subtractor #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
`ifdef SERSUB_SIGNED_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [N-1:0]   a_sr, a_sr_n;
    logic [N-1:0]   b_sr, b_sr_n;
    logic           br, br_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           ready_n, done_n, bout_n;
    logic [N-1:0]   diff_n;
    logic           d_bit_c, br_nx_c;
`ifdef SERSUB_SIGNED_OVF_EN
    logic           a_msb, a_msb_n, b_msb, b_msb_n, ovf_n;
`endif

    // Full-subtractor cell on the current LSBs
    assign d_bit_c = a_sr[0] ^ b_sr[0] ^ br;
    assign br_nx_c = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);

    always_comb begin
        state_n = state;
        a_sr_n  = a_sr;
        b_sr_n  = b_sr;
        br_n    = br;
        cnt_n   = cnt;
        diff_n  = diff;
        bout_n  = bout;
        done_n  = 1'b0;
`ifdef SERSUB_SIGNED_OVF_EN
        a_msb_n = a_msb;
        b_msb_n = b_msb;
        ovf_n   = ovf;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    a_sr_n  = a;
                    b_sr_n  = b;
                    br_n    = bin;
                    cnt_n   = '0;
                    state_n = SHIFT;
`ifdef SERSUB_SIGNED_OVF_EN
                    a_msb_n = a[N-1];
                    b_msb_n = b[N-1];
`endif
                end
            end
            SHIFT: begin
                diff_n = {d_bit_c, diff[N-1:1]};
                a_sr_n = a_sr >> 1;
                b_sr_n = b_sr >> 1;
                br_n   = br_nx_c;
                // Last bit: publish final borrow alongside the completed diff
                if (cnt == CW'(N - 1)) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                    bout_n  = br_nx_c;
`ifdef SERSUB_SIGNED_OVF_EN
                    ovf_n   = (a_msb != b_msb) && (d_bit_c != a_msb);
`endif
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        ready_n = (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERSUB_SIGNED_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            a_sr  <= a_sr_n;
            b_sr  <= b_sr_n;
            br    <= br_n;
            cnt   <= cnt_n;
            ready <= ready_n;
            done  <= done_n;
            diff  <= diff_n;
            bout  <= bout_n;
`ifdef SERSUB_SIGNED_OVF_EN
            a_msb <= a_msb_n;
            b_msb <= b_msb_n;
            ovf   <= ovf_n;
`endif
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: N=8 instance for scenarios, N=4 instance for a full sweep.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic       ready, done, bout;
    logic [7:0] diff;
`ifdef SERSUB_SIGNED_OVF_EN
    logic       ovf;
`endif

    logic       start4;
    logic [3:0] a4, b4;
    logic       bin4;
    logic       ready4, done4, bout4;
    logic [3:0] diff4;
`ifdef SERSUB_SIGNED_OVF_EN
    logic       ovf4;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .ready(ready), .done(done), .diff(diff), .bout(bout)
`ifdef SERSUB_SIGNED_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_subtractor #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .ready(ready4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERSUB_SIGNED_OVF_EN
        , .ovf(ovf4)
`endif
    );

    // Launch one N=8 op and wait (bounded) for done; lat = edges from acceptance to done
    task automatic run8(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin,
                        output int lat);
        @(posedge clk); #1;
        a = ta; b = tbv; bin = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'hAA; b = 8'h55; bin = 1'b1;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({ready, done, diff, bout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset: ready/done/diff/bout=%b/%b/%h/%b want 1/0/00/0", ready, done, diff, bout);
        end
`ifdef SERSUB_SIGNED_OVF_EN
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf: ovf=%b want 0", ovf);
        end
`endif
    endtask

    task automatic test_basic();
        int lat;
        run8(8'h05, 8'h03, 1'b0, lat);
        total++;
        if (lat != 8) begin
            bad++;
            $display("FAIL latency: got %0d want 8", lat);
        end
        total++;
        if ({diff, bout} !== {8'h02, 1'b0}) begin
            bad++;
            $display("FAIL sub_05_03: diff=%h bout=%b want 02/0", diff, bout);
        end
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_in_done: ready=%b want 0", ready);
        end
        @(posedge clk); #1;
        total++;
        if ({ready, done, diff} !== {1'b1, 1'b0, 8'h02}) begin
            bad++;
            $display("FAIL ready_after: ready/done/diff=%b/%b/%h want 1/0/02", ready, done, diff);
        end
    endtask

    task automatic test_borrow();
        int lat;
        run8(8'h03, 8'h05, 1'b0, lat);
        total++;
        if ({diff, bout} !== {8'hFE, 1'b1} || lat != 8) begin
            bad++;
            $display("FAIL sub_03_05: diff=%h bout=%b lat=%0d want FE/1/8", diff, bout, lat);
        end
        run8(8'h00, 8'h00, 1'b1, lat);
        total++;
        if ({diff, bout} !== {8'hFF, 1'b1} || lat != 8) begin
            bad++;
            $display("FAIL sub_00_00_bin: diff=%h bout=%b lat=%0d want FF/1/8", diff, bout, lat);
        end
        run8(8'hFF, 8'hFF, 1'b0, lat);
        total++;
        if ({diff, bout} !== {8'h00, 1'b0}) begin
            bad++;
            $display("FAIL sub_ff_ff: diff=%h bout=%b want 00/0", diff, bout);
        end
        run8(8'h00, 8'hFF, 1'b1, lat);
        total++;
        if ({diff, bout} !== {8'h00, 1'b1}) begin
            bad++;
            $display("FAIL sub_00_ff_bin: diff=%h bout=%b want 00/1", diff, bout);
        end
    endtask

    task automatic test_sweep4();
        logic [4:0] expv;
        int wait_cnt;
        for (int i = 0; i < 512; i++) begin
            @(posedge clk); #1;
            a4 = 4'(i); b4 = 4'(i >> 4); bin4 = 1'((i >> 8) & 1);
            expv = {1'b0, a4} - {1'b0, b4} - {4'b0, bin4};
            start4 = 1'b1;
            @(posedge clk); #1;
            start4 = 1'b0;
            wait_cnt = 0;
            while (!done4 && wait_cnt < 12) begin
                @(posedge clk); #1;
                wait_cnt++;
            end
            total++;
            if ({bout4, diff4} !== expv || wait_cnt != 4) begin
                bad++;
                $display("FAIL sweep4 a=%h b=%h bin=%b: bout/diff=%b/%h lat=%0d want %b/%h lat=4",
                         a4, b4, bin4, bout4, diff4, wait_cnt, expv[4], expv[3:0]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        @(posedge clk); #1;
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (done) dones++;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                total++;
                if ({diff, bout} !== {8'h0F, 1'b0}) begin
                    bad++;
                    $display("FAIL ignore_start: diff=%h bout=%b want 0F/0", diff, bout);
                end
            end
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL ignore_done_count: got %0d pulses want 1", dones);
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        int lat;
        @(posedge clk); #1;
        a = 8'h40; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++;
        if ({ready, done, diff, bout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL abort_state: ready/done/diff/bout=%b/%b/%h/%b want 1/0/00/0", ready, done, diff, bout);
        end
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d pulses want 0", dones);
        end
        run8(8'h40, 8'h11, 1'b0, lat);
        total++;
        if ({diff, bout} !== {8'h2F, 1'b0} || lat != 8) begin
            bad++;
            $display("FAIL after_abort: diff=%h bout=%b lat=%0d want 2F/0/8", diff, bout, lat);
        end
    endtask

`ifdef SERSUB_SIGNED_OVF_EN
    task automatic test_ovf();
        int lat;
        run8(8'h80, 8'h01, 1'b0, lat);
        total++;
        if ({diff, ovf, bout} !== {8'h7F, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL ovf_80_01: diff=%h ovf=%b bout=%b want 7F/1/0", diff, ovf, bout);
        end
        run8(8'h7F, 8'hFF, 1'b0, lat);
        total++;
        if ({diff, ovf, bout} !== {8'h80, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL ovf_7f_ff: diff=%h ovf=%b bout=%b want 80/1/1", diff, ovf, bout);
        end
        run8(8'h05, 8'h03, 1'b0, lat);
        total++;
        if ({diff, ovf} !== {8'h02, 1'b0}) begin
            bad++;
            $display("FAIL ovf_05_03: diff=%h ovf=%b want 02/0", diff, ovf);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_sweep4();
        test_ignore_start();
        test_abort();
`ifdef SERSUB_SIGNED_OVF_EN
        test_ovf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
